// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, single-word bus reads, skid buffer, registered IF/ID bundle
// Optional macro FETCH_STAT_EN enables the stat_bubbles counter (tied to 0 otherwise).
module fetch_stage #(
  parameter int unsigned          ADDR_W   = 27,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              bus_start,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  output logic [31:0]       stat_bubbles
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic                r_discard;
  logic                w_discard_next;
  logic [DATA_W-1:0]   r_buf_instr;
  logic [ADDR_W-1:0]   r_buf_pc;
  logic                w_buf_load;
  logic                w_deliver;
  logic [DATA_W-1:0]   w_deliver_instr;
  logic [ADDR_W-1:0]   w_deliver_pc;
  logic [DATA_W-1:0]   r_out_instr;
  logic [ADDR_W-1:0]   r_out_pc;
  logic                r_out_valid;

  // Gated by reset_n so the strobe stays low while reset is held, even though state is FETCH.
  assign bus_start = reset_n && (r_state == S_FETCH);
  assign bus_addr  = bus_start ? r_pc : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_pc_next;
      r_discard <= w_discard_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_pc_next       = r_pc;
    w_discard_next  = r_discard;
    w_buf_load      = 1'b0;
    w_deliver       = 1'b0;
    w_deliver_instr = bus_q;
    w_deliver_pc    = r_pc;
    case (r_state)
      S_FETCH: begin
        w_next_state = S_WAIT;
        if (flush_in) w_discard_next = 1'b1;
      end
      S_WAIT: begin
        if (bus_done) begin
          w_discard_next = 1'b0;
          if (r_discard || flush_in) begin
            w_next_state = S_FETCH;
          end else if (stall_in) begin
            w_buf_load   = 1'b1;
            w_pc_next    = r_pc + ADDR_W'(1);
            w_next_state = S_FULL;
          end else begin
            w_deliver    = 1'b1;
            w_pc_next    = r_pc + ADDR_W'(1);
            w_next_state = S_FETCH;
          end
        end else if (flush_in) begin
          // One discard tag covers the single outstanding read, however many flushes arrive.
          w_discard_next = 1'b1;
        end
      end
      S_FULL: begin
        if (flush_in) begin
          w_next_state = S_FETCH;
        end else if (!stall_in) begin
          w_deliver       = 1'b1;
          w_deliver_instr = r_buf_instr;
          w_deliver_pc    = r_buf_pc;
          w_next_state    = S_FETCH;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
    if (flush_in) w_pc_next = flush_pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else if (w_buf_load) begin
      r_buf_instr <= bus_q;
      r_buf_pc    <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (flush_in) begin
      r_out_valid <= 1'b0;
    end else if (!stall_in) begin
      r_out_valid <= w_deliver;
      if (w_deliver) begin
        r_out_instr <= w_deliver_instr;
        r_out_pc    <= w_deliver_pc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;

`ifdef FETCH_STAT_EN
  logic [31:0] r_stat_bubbles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_bubbles <= '0;
    end else if (!stall_in && (flush_in || !w_deliver)) begin
      r_stat_bubbles <= r_stat_bubbles + 32'd1;
    end
  end

  assign stat_bubbles = r_stat_bubbles;
`else
  assign stat_bubbles = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the CPU pipeline; directly upstream of the IF/ID stage register.
- Owns the program counter and issues single-word reads on the instruction bus.
- Presents a registered {instr, pc, valid} bundle to the IF/ID register.
- Honours downstream stall (hold) and redirect (flush/jump) requests; holds one fetched word in a skid buffer while stalled.

Parameters:
ADDR_W, 27, instruction address width (word-addressed)
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
stall_in  in  1  downstream hold: output bundle must not change
flush_in  in  1  redirect: discard in-flight/buffered work, restart at flush_pc
flush_pc  in  ADDR_W  redirect target, sampled when flush_in=1
bus_start  out  1  one-cycle read request strobe
bus_addr  out  ADDR_W  read address, valid while bus_start=1
bus_q  in  DATA_W  read data, valid when bus_done=1
bus_done  in  1  read complete, one-cycle pulse, earliest one cycle after bus_start
out_instr  out  DATA_W  instruction to IF/ID register
out_pc  out  ADDR_W  address of out_instr
out_valid  out  1  out_instr/out_pc are a real instruction (0 = bubble)
stat_bubbles  out  32  bubble counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=FETCH, discard=0, buffer empty; out_valid=0, out_instr=0, out_pc=0, bus_start=0, bus_addr=0, stat_bubbles=0. First bus_start in the first cycle after reset_n rises.
- FSM states:
  - FETCH: bus_start=1, bus_addr=pc for exactly one cycle -> WAIT.
  - WAIT: wait for bus_done.
    - bus_done, discard=1: drop word, clear discard -> FETCH.
    - bus_done, stall_in=0: word goes to output register, pc<=pc+1 -> FETCH.
    - bus_done, stall_in=1: word and pc go to skid buffer, pc<=pc+1 -> FULL.
  - FULL: when stall_in=0, buffer goes to output register, buffer empties -> FETCH.
- No new request is issued while in FULL: at most one word outstanding plus one buffered.
- Output register:
  - stall_in=1: out_* hold, including a held bubble.
  - stall_in=0: out_valid=1 with word/pc when a word is delivered this cycle; otherwise out_valid=0 (bubble), with out_instr and out_pc holding their values.
- Flush (priority over stall_in):
  - pc<=flush_pc; buffer emptied; out_valid<=0 on the next edge even if stall_in=1.
  - In WAIT without bus_done: discard<=1 and stay in WAIT.
  - In WAIT with bus_done the same cycle: drop word -> FETCH.
  - In FETCH: the issued request is tagged discard -> WAIT.
  - In FULL: -> FETCH.
  - The new pc is used by the next FETCH.
- Flush while discard=1: update pc only; a single discard still covers the one outstanding read.
- PC wraps modulo 2^ADDR_W (all-ones +1 -> 0).
- bus_done outside WAIT is ignored.
- Best-case throughput: 1 instruction per 2 cycles. Latency bus_done -> out_valid is 1 edge.

Optional Feature:
- Macro FETCH_STAT_EN.
- Defined: stat_bubbles is a 32-bit wrapping counter, incremented on every edge where stall_in=0 and out_valid is loaded with 0. Counts flush-induced bubbles; cycles with stall_in=1 are never counted. Reset to 0.
- Not defined: stat_bubbles tied to 0; no counter logic.

Test Plan:
- Reset release, RESET_PC=0x100, bus_done 1 cycle after each start, stall_in=0 -> bus_addr 0x100,0x101,0x102 on alternate cycles; out_pc 0x100,0x101,0x102 with out_valid pulsing 1,0,1,0.
- stall_in=1 for 5 cycles, asserted the cycle bus_done returns word 0xDEADBEEF@0x104 -> out_* frozen, no bus_start while in FULL; on release out_instr=0xDEADBEEF, out_pc=0x104, next bus_addr=0x105.
- flush_in=1, flush_pc=0x2000 during WAIT; stale bus_done 3 cycles later with 0x11111111 -> word never appears on out_*; next bus_addr=0x2000.
- flush_in and bus_done in the same cycle, stall_in=1 -> out_valid=0 next edge; next bus_addr=flush_pc.
- PC at 0x7FFFFFF (ADDR_W=27) fetched -> next bus_addr=0x0000000.
- reset_n pulsed low mid-WAIT -> all outputs 0 immediately (async); restart at RESET_PC. With FETCH_STAT_EN, 4 cycles of unstalled bubbles -> stat_bubbles=4, then 0 after reset.
